// File: rtl/packet_tx_sched_pkg.sv
// packet_tx_sched_pkg: shared types and constants for the TX frame scheduler.
package packet_tx_sched_pkg;
  localparam int UART_RX_FAW = 3;
  localparam int UART_MDW    = 8;
  localparam int BYTES_PF    = 2**UART_RX_FAW - 1;
  localparam int FIDX_W      = 6;
  typedef enum logic [2:0] {ST_IDLE, ST_H_ENC, ST_H_SEND, ST_GAP, ST_D_ENC, ST_D_SEND} tx_sched_st_e;
endpackage

// File: rtl/packet_tx_sched_if.sv
// packet_tx_sched_if: control bundle between the scheduler and front end, FEC, scrambler and serializer.
interface packet_tx_sched_if;
  import packet_tx_sched_pkg::*;
  logic                msg_start, busy, msg_done;
  logic [UART_MDW-1:0] msg_len, len_q;
  logic [3:0]          msg_tag, tag_q;
  logic                enc1_start, enc1_done, enc0_start, enc0_done, enc_used;
  logic                pkt_valid, pkt_ready;
  logic                err_inj_arm, err_inj_enable, err_inj_clr;
  logic [FIDX_W-1:0]   err_inj_frame, frame_idx;
  modport master (
    input  msg_start, msg_len, msg_tag, enc1_done, enc0_done, pkt_ready, err_inj_arm, err_inj_frame,
    output busy, msg_done, len_q, tag_q, enc1_start, enc0_start, enc_used, pkt_valid,
           err_inj_enable, err_inj_clr, frame_idx
  );
  modport slave (
    output msg_start, msg_len, msg_tag, enc1_done, enc0_done, pkt_ready, err_inj_arm, err_inj_frame,
    input  busy, msg_done, len_q, tag_q, enc1_start, enc0_start, enc_used, pkt_valid,
           err_inj_enable, err_inj_clr, frame_idx
  );
endinterface

// File: rtl/packet_tx_sched_tx_gap_cnt.sv
// tx_gap_cnt: loadable down-counter, done_o high once it has drained to zero.
module tx_gap_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/packet_tx_sched.sv
// packet_tx_sched: sequences a header frame and ceil(len/7) data frames through FEC/scrambler to the serializer.
module packet_tx_sched
  import packet_tx_sched_pkg::*;
#(
  parameter int IFG_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  packet_tx_sched_if.master tx_if
);
  localparam int GW = $clog2(IFG_CYCLES + 2);
  localparam logic [GW-1:0] GAP_LOAD = GW'(IFG_CYCLES > 0 ? IFG_CYCLES - 1 : 0);
  localparam logic [UART_MDW-1:0] BPF = UART_MDW'(BYTES_PF);
  localparam tx_sched_st_e DATA_NEXT = IFG_CYCLES == 0 ? ST_D_ENC : ST_GAP;
  tx_sched_st_e        st_q, st_d;
  logic [UART_MDW-1:0] rem_q, rem_d, len_q;
  logic [3:0]          tag_q;
  logic [FIDX_W-1:0]   idx_q, idx_d;
  logic                e1s_q, e0s_q, clr_q, done, gap_load, gap_done;
  logic                hs, start, last, inj;
  assign hs    = tx_if.pkt_valid & tx_if.pkt_ready;
  assign start = st_q == ST_IDLE & tx_if.msg_start;
  assign last  = rem_q <= BPF;
  assign inj   = tx_if.err_inj_arm & st_q == ST_D_SEND & idx_q == tx_if.err_inj_frame;
  tx_gap_cnt #(.W(GW)) u_gap (
    .clk(clk), .rst(rst), .load_i(gap_load), .val_i(GAP_LOAD), .done_o(gap_done)
  );
  always_comb begin
    st_d     = st_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    done     = 1'b0;
    gap_load = 1'b0;
    case (st_q)
      ST_IDLE: if (tx_if.msg_start) begin
        st_d  = ST_H_ENC;
        rem_d = tx_if.msg_len;
        idx_d = '0;
      end
      ST_H_ENC: st_d = tx_if.enc1_done ? ST_H_SEND : st_q;
      ST_H_SEND: if (hs) begin
        done     = rem_q == '0;
        st_d     = rem_q == '0 ? ST_IDLE : DATA_NEXT;
        gap_load = 1'b1;
      end
      ST_GAP: st_d = gap_done ? ST_D_ENC : st_q;
      ST_D_ENC: st_d = tx_if.enc0_done ? ST_D_SEND : st_q;
      ST_D_SEND: if (hs) begin
        done     = last;
        st_d     = last ? ST_IDLE : DATA_NEXT;
        rem_d    = last ? rem_q : rem_q - BPF;
        idx_d    = last ? idx_q : idx_q + 1'b1;
        gap_load = 1'b1;
      end
      default: st_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q  <= ST_IDLE;
      rem_q <= '0;
      len_q <= '0;
      tag_q <= '0;
      idx_q <= '0;
      e1s_q <= 1'b0;
      e0s_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      rem_q <= rem_d;
      idx_q <= idx_d;
      len_q <= start ? tx_if.msg_len : len_q;
      tag_q <= start ? tx_if.msg_tag : tag_q;
      e1s_q <= start;
      e0s_q <= st_d == ST_D_ENC & st_q != ST_D_ENC;
      clr_q <= hs & inj;
    end
  assign tx_if.busy           = st_q != ST_IDLE;
  assign tx_if.msg_done       = done;
  assign tx_if.len_q          = len_q;
  assign tx_if.tag_q          = tag_q;
  assign tx_if.enc1_start     = e1s_q;
  assign tx_if.enc0_start     = e0s_q;
  assign tx_if.enc_used       = st_q == ST_H_ENC | st_q == ST_H_SEND;
  assign tx_if.pkt_valid      = st_q == ST_H_SEND | st_q == ST_D_SEND;
  assign tx_if.err_inj_enable = inj;
  assign tx_if.err_inj_clr    = clr_q;
  assign tx_if.frame_idx      = idx_q;
endmodule

// File: tb/tb_packet_tx_sched.sv
// tb_packet_tx_sched: scoreboard bench; stimulus queues expected frames, monitor checks each handshake.
module tb_packet_tx_sched;
  localparam int IFG = 2;
  typedef struct {
    logic       eu;
    logic [5:0] idx;
    logic       inj;
    logic       done;
    logic [7:0] len;
    logic [3:0] tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  packet_tx_sched_if tx_if ();
  packet_tx_sched #(.IFG_CYCLES(IFG)) dut (.clk(clk), .rst(rst), .tx_if(tx_if));
  always #5 clk = ~clk;
  exp_t q[$];
  int vecs = 0, errs = 0;
  int cyc = 0, n_done = 0, n_e0 = 0, n_clr = 0, last_hs = -1, inj_hs = -1;
  int s_done = 0, s_e0 = 0, s_clr = 0;
  logic pv_prev = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic flag(input string nm);
    vecs++;
    errs++;
    $display("FAIL %s", nm);
  endtask
  function automatic logic [31:0] outs();
    return {tx_if.busy, tx_if.enc1_start, tx_if.enc0_start, tx_if.enc_used, tx_if.len_q, tx_if.tag_q,
            tx_if.pkt_valid, tx_if.err_inj_enable, tx_if.err_inj_clr, tx_if.frame_idx, tx_if.msg_done};
  endfunction
  initial begin
    tx_if.enc1_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_if.enc1_start) begin
        @(posedge clk);
        @(posedge clk);
        #1 tx_if.enc1_done = 1'b1;
        @(posedge clk);
        #1 tx_if.enc1_done = 1'b0;
      end
    end
  end
  initial begin
    tx_if.enc0_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_if.enc0_start) begin
        @(posedge clk);
        @(posedge clk);
        #1 tx_if.enc0_done = 1'b1;
        @(posedge clk);
        #1 tx_if.enc0_done = 1'b0;
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cyc++;
        if (tx_if.pkt_valid && !pv_prev && !tx_if.enc_used && last_hs >= 0)
          chk("ifg_idle", cyc - last_hs - 1, IFG + 3);
        if (tx_if.enc0_start) n_e0++;
        if (tx_if.msg_done) n_done++;
        if (tx_if.err_inj_clr) begin
          n_clr++;
          chk("clr_timing", cyc, inj_hs + 1);
        end
        if (tx_if.pkt_valid && tx_if.pkt_ready) begin
          if (q.size() == 0) flag("unexpected_frame");
          else begin
            e = q.pop_front();
            chk("enc_used", tx_if.enc_used, e.eu);
            if (!e.eu) chk("frame_idx", tx_if.frame_idx, e.idx);
            chk("err_inj_enable", tx_if.err_inj_enable, e.inj);
            chk("msg_done", tx_if.msg_done, e.done);
            chk("len_q", tx_if.len_q, e.len);
            chk("tag_q", tx_if.tag_q, e.tag);
            if (e.inj) inj_hs = cyc;
          end
          last_hs = cyc;
        end else if (tx_if.msg_done) flag("done_without_handshake");
        pv_prev = tx_if.pkt_valid;
      end else begin
        pv_prev = 1'b0;
        last_hs = -1;
      end
    end
  end
  task automatic start_msg(input int len, input int tag, input logic arm, input int fr);
    int n;
    exp_t e;
    n = (len + 6) / 7;
    s_done = n_done;
    s_e0 = n_e0;
    s_clr = n_clr;
    e.eu = 1'b1; e.idx = '0; e.inj = 1'b0; e.done = n == 0; e.len = len[7:0]; e.tag = tag[3:0];
    q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.eu = 1'b0; e.idx = i[5:0]; e.inj = arm && i == fr; e.done = i == n - 1;
      q.push_back(e);
    end
    tx_if.err_inj_arm = arm;
    tx_if.err_inj_frame = fr[5:0];
    tx_if.msg_len = len[7:0];
    tx_if.msg_tag = tag[3:0];
    tx_if.msg_start = 1'b1;
    @(posedge clk);
    #1 tx_if.msg_start = 1'b0;
  endtask
  task automatic wait_idle(input string nm, input int frames, input int clrs);
    int k;
    k = 0;
    while (tx_if.busy && k < 5000) begin
      @(posedge clk);
      #1 k++;
    end
    if (tx_if.busy) flag({nm, "_timeout"});
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_done_pulses"}, n_done - s_done, 1);
    chk({nm, "_enc0_starts"}, n_e0 - s_e0, frames);
    chk({nm, "_clr_pulses"}, n_clr - s_clr, clrs);
    chk({nm, "_queue_left"}, q.size(), 0);
  endtask
  task automatic wait_enc0(input string nm);
    int k;
    k = 0;
    while (!tx_if.enc0_start && k < 200) begin
      @(posedge clk);
      #1 k++;
    end
    if (!tx_if.enc0_start) flag({nm, "_no_enc0_start"});
  endtask
  initial begin
    logic [8:0] snap;
    logic stable;
    int k;
    tx_if.msg_start = 1'b0;
    tx_if.msg_len = '0;
    tx_if.msg_tag = '0;
    tx_if.pkt_ready = 1'b1;
    tx_if.err_inj_arm = 1'b0;
    tx_if.err_inj_frame = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start_msg(0, 5, 1'b0, 0);
    wait_idle("len0", 0, 0);
    start_msg(14, 3, 1'b0, 0);
    wait_idle("len14", 2, 0);
    start_msg(15, 10, 1'b0, 0);
    wait_idle("len15", 3, 0);
    start_msg(255, 15, 1'b0, 0);
    wait_idle("len255", 37, 0);
    start_msg(21, 9, 1'b1, 1);
    wait_idle("inj1", 3, 1);
    tx_if.err_inj_arm = 1'b0;
    start_msg(21, 6, 1'b1, 9);
    wait_idle("inj9", 3, 0);
    start_msg(14, 2, 1'b1, 0);
    wait_enc0("stall");
    tx_if.pkt_ready = 1'b0;
    k = 0;
    while (!tx_if.pkt_valid && k < 200) begin
      @(posedge clk);
      #1 k++;
    end
    snap = {tx_if.pkt_valid, tx_if.enc_used, tx_if.err_inj_enable, tx_if.frame_idx};
    chk("stall_entry", snap, {1'b1, 1'b0, 1'b1, 6'd0});
    stable = 1'b1;
    tx_if.msg_len = 8'd200;
    for (int i = 0; i < 20; i++) begin
      tx_if.msg_start = i == 5;
      @(posedge clk);
      #1 stable &= {tx_if.pkt_valid, tx_if.enc_used, tx_if.err_inj_enable, tx_if.frame_idx} == snap;
    end
    tx_if.msg_start = 1'b0;
    chk("stall_stable", stable, 1);
    chk("stall_busy", tx_if.busy, 1);
    tx_if.pkt_ready = 1'b1;
    wait_idle("stall", 2, 1);
    tx_if.err_inj_arm = 1'b0;
    start_msg(21, 1, 1'b0, 0);
    wait_enc0("abort");
    #2 rst = 1'b1;
    #1 chk("abort_outputs", outs(), 0);
    q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start_msg(7, 4, 1'b0, 0);
    wait_idle("after_rst", 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
